// File: rtl/time_keeper.sv
// Countdown timer: loads a clamped BCD HH:MM:SS value, then decrements it once
// per TICK_DIV clocks and raises alarm when it reaches 00:00:00.
module time_keeper #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [3:0]  state,
    input  logic [23:0] controlledToggleSwitchBits,
    output logic [23:0] timeBCD,
    output logic        running,
    output logic        alarm,
    output logic [1:0]  timerState
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST_COUNT = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADED  = 2'd1,
        RUNNING = 2'd2,
        EXPIRED = 2'd3
    } fsmState_t;

    typedef enum logic [3:0] {
        CMD_RESET = 4'd0,
        CMD_SET   = 4'd1,
        CMD_LOAD  = 4'd2,
        CMD_START = 4'd3,
        CMD_IDLE  = 4'd4
    } command_t;

    fsmState_t     timerFsm;
    logic [PW-1:0] prescaler;
    logic [23:0]   clampedTime;
    logic [23:0]   decrementedTime;

    function automatic logic [23:0] clampTime(input logic [23:0] t);
        logic [3:0] hTens, hUnits, mTens, mUnits, sTens, sUnits;
        hTens  = (t[23:20] > 4'd1) ? 4'd1 : t[23:20];
        hUnits = (t[19:16] > 4'd9) ? 4'd9 : t[19:16];
        mTens  = (t[15:12] > 4'd5) ? 4'd5 : t[15:12];
        mUnits = (t[11:8]  > 4'd9) ? 4'd9 : t[11:8];
        sTens  = (t[7:4]   > 4'd5) ? 4'd5 : t[7:4];
        sUnits = (t[3:0]   > 4'd9) ? 4'd9 : t[3:0];
        // Hours 13..19 saturate to 12; minutes and seconds are kept as clamped.
        if (hTens == 4'd1 && hUnits > 4'd2) begin
            hUnits = 4'd2;
        end
        return {hTens, hUnits, mTens, mUnits, sTens, sUnits};
    endfunction

    function automatic logic [23:0] decrementTime(input logic [23:0] t);
        logic [23:0] r;
        r = t;
        if (t[3:0] != 4'd0) begin
            r[3:0] = t[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (t[7:4] != 4'd0) begin
                r[7:4] = t[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (t[11:8] != 4'd0) begin
                    r[11:8] = t[11:8] - 4'd1;
                end else begin
                    r[11:8] = 4'd9;
                    if (t[15:12] != 4'd0) begin
                        r[15:12] = t[15:12] - 4'd1;
                    end else begin
                        r[15:12] = 4'd5;
                        if (t[19:16] != 4'd0) begin
                            r[19:16] = t[19:16] - 4'd1;
                        end else begin
                            r[19:16] = 4'd9;
                            r[23:20] = t[23:20] - 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        clampedTime     = clampTime(controlledToggleSwitchBits);
        decrementedTime = decrementTime(timeBCD);
    end

    assign timerState = timerFsm;

    always_ff @(posedge clk) begin
        if (!resetN || state == CMD_RESET) begin
            timerFsm  <= IDLE;
            timeBCD   <= '0;
            prescaler <= '0;
            running   <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            case (timerFsm)
                IDLE, LOADED: begin
                    prescaler <= '0;
                    if (state == CMD_SET) begin
                        timeBCD  <= clampedTime;
                        timerFsm <= LOADED;
                    end else if (timerFsm == LOADED && state == CMD_START && timeBCD != '0) begin
                        timerFsm <= RUNNING;
                        running  <= 1'b1;
                    end
                end
                RUNNING: begin
                    // Commands other than reset are ignored once the countdown is latched.
                    if (prescaler == LAST_COUNT) begin
                        prescaler <= '0;
                        timeBCD   <= decrementedTime;
                        if (decrementedTime == '0) begin
                            timerFsm <= EXPIRED;
                            running  <= 1'b0;
                            alarm    <= 1'b1;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                EXPIRED: begin
                    timeBCD   <= '0;
                    prescaler <= '0;
                    running   <= 1'b0;
                    alarm     <= 1'b1;
                end
            endcase
        end
    end

endmodule
